// File: rtl/i2c_slave.sv
// I2C target: oversampled SCL/SDA, 7-bit address match, 8-bit auto-incrementing
// sub-address, byte-wide register write/read port, open-drain SDA pad split.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1101000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_out,
    output logic       i2c_sda_out_mode,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_SUB,
        S_SUB_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_IGNORE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] scl_sync_q, scl_sync_d;
    logic [2:0] sda_sync_q, sda_sync_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       reg_we_q, reg_we_d;
    logic       wr_pend_q, wr_pend_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic scl_s2, scl_s3, sda_s2, sda_s3;
    logic scl_rise, scl_fall, bus_start, bus_stop;

    // Stage 1 and 2 synchronise; stage 3 is the previous value for edge detection.
    assign scl_s2    = scl_sync_q[1];
    assign scl_s3    = scl_sync_q[2];
    assign sda_s2    = sda_sync_q[1];
    assign sda_s3    = sda_sync_q[2];
    assign scl_rise  = scl_s2 & ~scl_s3;
    assign scl_fall  = ~scl_s2 & scl_s3;
    assign bus_start = scl_s2 & scl_s3 & ~sda_s2 & sda_s3;
    assign bus_stop  = scl_s2 & scl_s3 & sda_s2 & ~sda_s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            wr_pend_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            wr_pend_q   <= wr_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        scl_sync_d  = {scl_sync_q[1:0], i2c_scl};
        sda_sync_d  = {sda_sync_q[1:0], i2c_sda_in};
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        wr_pend_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;

        // Write strobe trails the 8th rise by one clk; the pointer bumps one clk later.
        if (wr_pend_q) begin
            reg_we_d    = 1'b1;
            reg_wdata_d = shift_q;
        end
        if (reg_we_q) begin
            reg_addr_d = reg_addr_q + 8'd1;
        end

        if (bus_start) begin
            state_d   = S_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (bus_stop) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            done_d   = busy_q;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_SUB, S_WDATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s2};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7 && state_q == S_SUB) begin
                            reg_addr_d = {shift_q[6:0], sda_s2};
                        end
                        if (bit_cnt_q == 4'd7 && state_q == S_WDATA) begin
                            wr_pend_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (state_q == S_ADDR) begin
                            if (shift_q[7:1] == SLAVE_ADDR) begin
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                                rw_d     = shift_q[0];
                                state_d  = S_ADDR_ACK;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end else begin
                            sda_oe_d = 1'b1;
                            state_d  = (state_q == S_SUB) ? S_SUB_ACK : S_WDATA_ACK;
                        end
                    end
                end
                S_ADDR_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        if (state_q == S_ADDR_ACK && rw_q) begin
                            shift_d  = reg_rdata;
                            sda_oe_d = ~reg_rdata[7];
                            state_d  = S_RDATA;
                        end else if (state_q == S_ADDR_ACK) begin
                            state_d = S_SUB;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = S_RDATA_ACK;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                S_RDATA_ACK: begin
                    // bit_cnt marks that the master ACK has been sampled on this bit.
                    if (scl_rise && bit_cnt_q == 4'd0) begin
                        reg_addr_d = reg_addr_q + 8'd1;
                        if (sda_s2) begin
                            state_d = S_IGNORE;
                        end else begin
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        shift_d   = reg_rdata;
                        sda_oe_d  = ~reg_rdata[7];
                        bit_cnt_d = '0;
                        state_d   = S_RDATA;
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign i2c_sda_out      = 1'b0;
    assign i2c_sda_out_mode = sda_oe_q;
    assign reg_addr         = reg_addr_q;
    assign reg_wdata        = reg_wdata_q;
    assign reg_we           = reg_we_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule
